// File: rtl/mem_access_unit.sv
// mem_access_unit: multicycle memory-access sequencer for the unified
// instruction/data memory. Converts the controller's per-state strobes into
// a registered valid/ready bus transaction, stalls the FSM until the access
// completes, then latches the fetched instruction, its PC, or load data.
module mem_access_unit #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IRWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              AdrSrc,
    input  logic [2:0]        funct3,
    input  logic [31:0]       PC,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       WriteData,
    output logic [31:0]       Instr,
    output logic [31:0]       OldPC,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              misaligned,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Per-access context captured when the request is accepted
    logic [1:0]  lane;
    logic [2:0]  size_f3;
    logic        is_fetch;
    logic [31:0] pc_copy;

    logic              req;
    logic              fetch_sel;
    logic [31:0]       acc_addr;
    logic [2:0]        nbytes;
    logic              mis_now;
    logic [3:0]        be_next;
    logic [31:0]       wdata_next;
    logic [ADDR_W-1:0] addr_next;

    // Number of bytes touched by the access. Fetches are always words; store
    // and load encodings differ only in that loads also have BU/HU.
    function automatic logic [2:0] access_bytes(input logic fetch, input logic store,
                                                input logic [2:0] f3);
        logic [2:0] n;
        n = 3'd4;
        if (!fetch) begin
            if (store) begin
                case (f3)
                    3'b000:  n = 3'd1;
                    3'b001:  n = 3'd2;
                    default: n = 3'd4;
                endcase
            end else begin
                case (f3)
                    3'b000, 3'b100: n = 3'd1;
                    3'b001, 3'b101: n = 3'd2;
                    default:        n = 3'd4;
                endcase
            end
        end
        return n;
    endfunction

    // Halfwords must sit on even addresses, words on multiples of four
    function automatic logic is_misaligned(input logic [2:0] n, input logic [1:0] a);
        return ((n == 3'd2) && a[0]) || ((n == 3'd4) && (a != 2'b00));
    endfunction

    // Byte enables for the lanes a store touches; reads enable the full word
    function automatic logic [3:0] store_be(input logic store, input logic [2:0] n,
                                            input logic [1:0] a);
        logic [3:0] be;
        be = 4'b1111;
        if (store) begin
            case (n)
                3'd1:    be = 4'b0001 << a;
                3'd2:    be = 4'b0011 << {a[1], 1'b0};
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // Store data replicated across all lanes so the enabled lane sees it
    function automatic logic [31:0] store_wdata(input logic store, input logic [2:0] n,
                                                input logic [31:0] wd);
        logic [31:0] d;
        d = 32'h0;
        if (store) begin
            case (n)
                3'd1:    d = {4{wd[7:0]}};
                3'd2:    d = {2{wd[15:0]}};
                default: d = wd;
            endcase
        end
        return d;
    endfunction

    // Pick the addressed byte/halfword out of the word and extend it
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rd >> {a, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b100:  r = {24'h0, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b101:  r = {16'h0, sh[15:0]};
            default: r = rd;
        endcase
        return r;
    endfunction

    assign req        = IRWrite | MemRead | MemWrite;
    // A store wins over a simultaneous fetch; the fetch address is always PC
    assign fetch_sel  = IRWrite & ~MemWrite;
    assign acc_addr   = fetch_sel ? PC : (AdrSrc ? ALUResult : PC);
    assign nbytes     = access_bytes(fetch_sel, MemWrite, funct3);
    assign mis_now    = is_misaligned(nbytes, acc_addr[1:0]);
    assign be_next    = store_be(MemWrite, nbytes, acc_addr[1:0]);
    assign wdata_next = store_wdata(MemWrite, nbytes, WriteData);

    generate
        if (ADDR_W > 32) begin : g_addr_wide
            assign addr_next = {{(ADDR_W - 32){1'b0}}, acc_addr[31:2], 2'b00};
        end else begin : g_addr_narrow
            assign addr_next = {acc_addr[ADDR_W-1:2], 2'b00};
        end
    endgenerate

    // Freeze the controller from request acceptance until the DONE cycle
    assign Stall = reset & (((state == IDLE) & req) | (state == REQ));

    // Sequencer: accepts a request, drives the bus until ready, captures result
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            bus_valid  <= 1'b0;
            bus_we     <= 1'b0;
            bus_be     <= 4'b0000;
            bus_addr   <= '0;
            bus_wdata  <= 32'h0;
            Instr      <= NOP_INSTR;
            OldPC      <= 32'h0;
            ReadData   <= 32'h0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (mis_now) begin
                            misaligned <= 1'b1;
                            ReadData   <= 32'h0;
                            state      <= DONE;
                        end else begin
                            bus_valid <= 1'b1;
                            bus_we    <= MemWrite;
                            bus_be    <= be_next;
                            bus_addr  <= addr_next;
                            bus_wdata <= wdata_next;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        if (is_fetch) begin
                            Instr <= bus_rdata;
                            OldPC <= pc_copy;
                        end else if (!bus_we) begin
                            ReadData <= load_extend(size_f3, lane, bus_rdata);
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Access context; only meaningful while a bus transaction is outstanding
    always_ff @(posedge clk) begin
        if ((state == IDLE) && req && !mis_now) begin
            lane     <= acc_addr[1:0];
            size_f3  <= funct3;
            is_fetch <= fetch_sel;
            pc_copy  <= PC;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset
// corner cases and randomized accesses against a behavioural model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        IRWrite, MemRead, MemWrite, AdrSrc;
    logic [2:0]  funct3;
    logic [31:0] PC, ALUResult, WriteData;
    logic [31:0] Instr, OldPC, ReadData;
    logic        Stall, misaligned;
    logic        bus_valid, bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    // Architectural state as the model believes it
    logic [31:0] m_instr, m_oldpc, m_rd;

    typedef struct {
        logic        irw, mrd, mwr, adrsrc;
        logic [2:0]  f3;
        logic [31:0] pc, alu, wd, rdata;
        int          waits;
        logic        exp_mis;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_instr, exp_oldpc, exp_rd;
    } vec_t;

    vec_t tbl[13];

    mem_access_unit #(.ADDR_W(32), .NOP_INSTR(32'h00000013)) dut (
        .clk(clk), .reset(reset),
        .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .funct3(funct3), .PC(PC), .ALUResult(ALUResult), .WriteData(WriteData),
        .Instr(Instr), .OldPC(OldPC), .ReadData(ReadData),
        .Stall(Stall), .misaligned(misaligned),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_be(bus_be),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic irw, input logic mrd, input logic mwr,
                                input logic adrsrc, input logic [2:0] f3,
                                input logic [31:0] pc, input logic [31:0] alu,
                                input logic [31:0] wd, input logic [31:0] rdata,
                                input int waits);
        vec_t v;
        v.irw = irw; v.mrd = mrd; v.mwr = mwr; v.adrsrc = adrsrc; v.f3 = f3;
        v.pc = pc; v.alu = alu; v.wd = wd; v.rdata = rdata; v.waits = waits;
        v.exp_mis = 1'b0; v.exp_addr = 32'h0; v.exp_be = 4'h0; v.exp_we = 1'b0;
        v.exp_wdata = 32'h0; v.exp_instr = 32'h0; v.exp_oldpc = 32'h0; v.exp_rd = 32'h0;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t vi, input logic mis, input logic [31:0] addr,
                                input logic [3:0] be, input logic we, input logic [31:0] wdata,
                                input logic [31:0] instr, input logic [31:0] oldpc,
                                input logic [31:0] rd);
        vec_t v;
        v = vi;
        v.exp_mis = mis; v.exp_addr = addr; v.exp_be = be; v.exp_we = we;
        v.exp_wdata = wdata; v.exp_instr = instr; v.exp_oldpc = oldpc; v.exp_rd = rd;
        return v;
    endfunction

    // Reference model: works in bytes and offsets, updates m_* as a side effect
    function automatic vec_t model(input vec_t vi);
        vec_t        v;
        bit          st, fe;
        logic [31:0] a, sh, val;
        int          off, nb, be_i;
        v   = vi;
        st  = vi.mwr;
        fe  = vi.irw && !vi.mwr;
        a   = fe ? vi.pc : (vi.adrsrc ? vi.alu : vi.pc);
        off = int'(a % 4);
        if (fe)      nb = 4;
        else if (st) nb = (vi.f3 == 3'd0) ? 1 : (vi.f3 == 3'd1) ? 2 : 4;
        else         nb = (vi.f3 == 3'd0 || vi.f3 == 3'd4) ? 1 :
                          (vi.f3 == 3'd1 || vi.f3 == 3'd5) ? 2 : 4;
        v.exp_mis  = (off % nb) != 0;
        v.exp_addr = a - off;
        v.exp_we   = st;
        if (st) begin
            be_i        = ((1 << nb) - 1) << off;
            v.exp_be    = be_i[3:0];
            v.exp_wdata = (nb == 1) ? (vi.wd & 32'hFF) * 32'h01010101 :
                          (nb == 2) ? (vi.wd & 32'hFFFF) * 32'h00010001 : vi.wd;
        end else begin
            v.exp_be    = 4'hF;
            v.exp_wdata = 32'h0;
        end
        if (v.exp_mis) begin
            m_rd = 32'h0;
        end else if (fe) begin
            m_instr = vi.rdata;
            m_oldpc = vi.pc;
        end else if (!st) begin
            sh = vi.rdata >> (8 * off);
            if (nb == 1) begin
                val = sh & 32'hFF;
                if (vi.f3 == 3'd0 && val >= 32'd128) val = val + 32'hFFFFFF00;
            end else if (nb == 2) begin
                val = sh & 32'hFFFF;
                if (vi.f3 == 3'd1 && val >= 32'd32768) val = val + 32'hFFFF0000;
            end else begin
                val = vi.rdata;
            end
            m_rd = val;
        end
        v.exp_instr = m_instr;
        v.exp_oldpc = m_oldpc;
        v.exp_rd    = m_rd;
        return v;
    endfunction

    task automatic clear_inputs();
        IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; bus_ready = 1'b0;
    endtask

    // Called just after a rising edge with the DUT in IDLE
    task automatic run_vec(input vec_t v, input string nm);
        int stall_cnt;
        int valid_cnt;
        bit done;
        stall_cnt = 0; valid_cnt = 0; done = 1'b0;
        IRWrite = v.irw; MemRead = v.mrd; MemWrite = v.mwr; AdrSrc = v.adrsrc;
        funct3 = v.f3; PC = v.pc; ALUResult = v.alu; WriteData = v.wd;
        bus_rdata = v.rdata;
        bus_ready = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            if (bus_valid) begin
                valid_cnt++;
                check($sformatf("%s_addr", nm), bus_addr, v.exp_addr);
                check($sformatf("%s_be", nm), {28'h0, bus_be}, {28'h0, v.exp_be});
                check($sformatf("%s_we", nm), {31'h0, bus_we}, {31'h0, v.exp_we});
                check($sformatf("%s_wdata", nm), bus_wdata, v.exp_wdata);
                bus_ready = (valid_cnt > v.waits);
                if (valid_cnt == 1) begin
                    PC = $urandom; ALUResult = $urandom; WriteData = $urandom;
                    funct3 = 3'($urandom_range(0, 7)); AdrSrc = ~AdrSrc;
                end
            end
            if (Stall) begin
                stall_cnt++;
            end else begin
                done = 1'b1;
                check($sformatf("%s_stall_cycles", nm), stall_cnt, v.exp_mis ? 1 : 2 + v.waits);
                check($sformatf("%s_valid_cycles", nm), valid_cnt, v.exp_mis ? 0 : v.waits + 1);
                check($sformatf("%s_mis", nm), {31'h0, misaligned}, {31'h0, v.exp_mis});
                check($sformatf("%s_instr", nm), Instr, v.exp_instr);
                check($sformatf("%s_oldpc", nm), OldPC, v.exp_oldpc);
                check($sformatf("%s_readdata", nm), ReadData, v.exp_rd);
                clear_inputs();
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got stall still high expected DONE within 64 cycles", nm);
            clear_inputs();
            reset = 1'b0; @(posedge clk); #1; reset = 1'b1;
        end
        @(negedge clk);
        check($sformatf("%s_mis_pulse_end", nm), {31'h0, misaligned}, 32'h0);
        check($sformatf("%s_idle_stall", nm), {31'h0, Stall}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        IRWrite = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; AdrSrc = 1'b0;
        funct3 = 3'b000; PC = 32'h0; ALUResult = 32'h0; WriteData = 32'h0;
        bus_ready = 1'b1; bus_rdata = 32'hFFFFFFFF;

        // Reset values, with a request pending to show Stall stays low
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
        check("rst_bus_we", {31'h0, bus_we}, 32'h0);
        check("rst_bus_be", {28'h0, bus_be}, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_instr", Instr, 32'h00000013);
        check("rst_oldpc", OldPC, 32'h0);
        check("rst_readdata", ReadData, 32'h0);
        check("rst_mis", {31'h0, misaligned}, 32'h0);
        check("rst_stall", {31'h0, Stall}, 32'h0);
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;

        tbl[0]  = ex(mk(1,0,0,0,3'b000, 32'h100, 32'h0,   32'h0,        32'h00500093, 0),
                     0, 32'h100, 4'b1111, 0, 32'h0,        32'h00500093, 32'h100, 32'h0);
        tbl[1]  = ex(mk(0,0,1,1,3'b000, 32'h104, 32'h203, 32'h123456AB, 32'hDEADBEEF, 0),
                     0, 32'h200, 4'b1000, 1, 32'hABABABAB, 32'h00500093, 32'h100, 32'h0);
        tbl[2]  = ex(mk(0,1,0,1,3'b000, 32'h104, 32'h202, 32'h0,        32'h12F03456, 0),
                     0, 32'h200, 4'b1111, 0, 32'h0,        32'h00500093, 32'h100, 32'hFFFFFFF0);
        tbl[3]  = ex(mk(0,1,0,1,3'b100, 32'h104, 32'h202, 32'h0,        32'h12F03456, 0),
                     0, 32'h200, 4'b1111, 0, 32'h0,        32'h00500093, 32'h100, 32'h000000F0);
        tbl[4]  = ex(mk(0,1,0,1,3'b001, 32'h104, 32'h202, 32'h0,        32'h12F03456, 0),
                     0, 32'h200, 4'b1111, 0, 32'h0,        32'h00500093, 32'h100, 32'h000012F0);
        tbl[5]  = ex(mk(0,1,0,1,3'b010, 32'h104, 32'h40,  32'h0,        32'hCAFEF00D, 3),
                     0, 32'h40,  4'b1111, 0, 32'h0,        32'h00500093, 32'h100, 32'hCAFEF00D);
        tbl[6]  = ex(mk(0,0,1,1,3'b001, 32'h104, 32'h202, 32'h0000BEEF, 32'h0,        1),
                     0, 32'h200, 4'b1100, 1, 32'hBEEFBEEF, 32'h00500093, 32'h100, 32'hCAFEF00D);
        tbl[7]  = ex(mk(1,0,1,1,3'b010, 32'h400, 32'h300, 32'h11223344, 32'h55555555, 0),
                     0, 32'h300, 4'b1111, 1, 32'h11223344, 32'h00500093, 32'h100, 32'hCAFEF00D);
        tbl[8]  = ex(mk(0,1,0,1,3'b101, 32'h104, 32'h202, 32'h0,        32'h80017FFF, 2),
                     0, 32'h200, 4'b1111, 0, 32'h0,        32'h00500093, 32'h100, 32'h00008001);
        tbl[9]  = ex(mk(0,1,0,1,3'b001, 32'h104, 32'h200, 32'h0,        32'h12348000, 0),
                     0, 32'h200, 4'b1111, 0, 32'h0,        32'h00500093, 32'h100, 32'hFFFF8000);
        tbl[10] = ex(mk(0,1,0,0,3'b100, 32'h201, 32'h0,   32'h0,        32'h0000AB00, 0),
                     0, 32'h200, 4'b1111, 0, 32'h0,        32'h00500093, 32'h100, 32'h000000AB);
        tbl[11] = ex(mk(0,1,0,1,3'b010, 32'h104, 32'h206, 32'h0,        32'h77777777, 0),
                     1, 32'h0,   4'b0000, 0, 32'h0,        32'h00500093, 32'h100, 32'h0);
        tbl[12] = ex(mk(1,0,0,0,3'b000, 32'h102, 32'h0,   32'h0,        32'h99999999, 0),
                     1, 32'h0,   4'b0000, 0, 32'h0,        32'h00500093, 32'h100, 32'h0);

        for (int i = 0; i < 13; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset while a fetch is waiting for bus_ready
        IRWrite = 1'b1; PC = 32'h500; bus_ready = 1'b0; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("rstreq_stall", {31'h0, Stall}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstreq_valid", {31'h0, bus_valid}, 32'h1);
        reset = 1'b0; bus_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstreq_bus_valid", {31'h0, bus_valid}, 32'h0);
        check("rstreq_instr", Instr, 32'h00000013);
        check("rstreq_oldpc", OldPC, 32'h0);
        check("rstreq_readdata", ReadData, 32'h0);
        check("rstreq_stall_low", {31'h0, Stall}, 32'h0);
        clear_inputs();
        reset = 1'b1;
        m_instr = 32'h00000013; m_oldpc = 32'h0; m_rd = 32'h0;
        @(posedge clk); #1;
        run_vec(model(mk(1,0,0,0,3'b000, 32'h104, 32'h0, 32'h0, 32'h00A00113, 1)), "postrst");

        // Randomized accesses against the model
        for (int i = 0; i < 150; i++) begin
            vec_t v;
            int   op;
            op = $urandom_range(0, 2);
            v = mk(op == 0, op == 1, op == 2, 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)),
                   ($urandom_range(0, 255) * 4) + (($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0),
                   $urandom & 32'h0000FFFF, $urandom, $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) v.irw = 1'b1;
            v = model(v);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle memory-access sequencer between the controller FSM and the unified instruction/data memory. Turns the controller's per-state memory strobes (IRWrite, MemWrite, load read) into a registered valid/ready bus transaction. Holds the FSM with `Stall` until the access completes, then latches the instruction, OldPC or load data. Also generates byte enables, write-data lanes, load sign/zero extension and misalignment detection.

## Interface
- `ADDR_W`, 32: bus address width. Upper bits pass through; `[1:0]` select the byte lane.
- `NOP_INSTR`, 32'h00000013: reset value of `Instr`.

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low. Sampled on `clk`.
- `IRWrite` in 1: fetch request. The read address is always `PC`, regardless of `AdrSrc`.
- `MemRead` in 1: load request (controller MemRead state).
- `MemWrite` in 1: store request.
- `AdrSrc` in 1: selects the load/store address. 0 = `PC`, 1 = `ALUResult`.
- `funct3` in 3: load/store size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `PC` in 32: current PC.
- `ALUResult` in 32: computed data address.
- `WriteData` in 32: store source (rs2).
- `Instr` out 32: instruction register.
- `OldPC` out 32: PC of the fetched instruction.
- `ReadData` out 32: extended load data.
- `Stall` out 1: freezes the controller FSM state register while high.
- `misaligned` out 1: one-cycle pulse on a misaligned access.
- `bus_valid` out 1, `bus_we` out 1, `bus_be` out 4, `bus_addr` out ADDR_W, `bus_wdata` out 32: registered request channel.
- `bus_ready` in 1, `bus_rdata` in 32: memory response.

## Operation
- States: IDLE, REQ, DONE.
- `req = IRWrite | MemRead | MemWrite`.
- **IDLE.** When `req` is high, latch the following, then go to REQ:
  - `bus_addr` = access address with `[1:0]` cleared.
  - `bus_we` = `MemWrite`.
  - `bus_be` and `bus_wdata` (see lane rules below).
  - Internal copies of address bits `[1:0]`, `funct3`, fetch flag and `PC`.
  - Set `bus_valid=1` on the same edge.
- **Priority.** `MemWrite` beats `IRWrite`/`MemRead` when both are set. `Instr` is not updated in that case.
- **Misaligned access.** Fetch or W with `addr[1:0]!=0`, or H/HU with `addr[0]=1`:
  - No bus request.
  - Go directly IDLE→DONE.
  - Pulse `misaligned` for 1 cycle.
  - `ReadData` is set to 0; `Instr` and memory are untouched.
- **REQ.** Hold `bus_valid`, `bus_addr`, `bus_we`, `bus_be` and `bus_wdata` stable until `bus_ready=1`. On that edge:
  - Drop `bus_valid`.
  - Capture the result: fetch → `Instr=bus_rdata`, `OldPC=PC` copy; load → `ReadData` = extended `bus_rdata`; store → nothing.
  - Go to DONE.
- **DONE.** `Stall=0` for exactly one cycle, so the FSM advances on this edge. Unconditionally return to IDLE.
  - A request present in the following cycle starts a new access. There are no back-to-back transfers without passing through IDLE.
- **Stall.** Combinational: `reset & ((IDLE & req) | REQ)`.
- **Store lanes.**
  - SB: `be = 4'b0001 << a[1:0]`, `wdata = {4{WriteData[7:0]}}`.
  - SH: `be = 4'b0011 << {a[1],1'b0}`, `wdata = {2{WriteData[15:0]}}`.
  - SW: `be = 4'b1111`, `wdata = WriteData`.
  - Reads: `be = 4'b1111`, `wdata = 0`.
- **Load extension.** Select the byte/halfword by the latched `a[1:0]`.
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
  - Any other `funct3`: treated as W.

## Timing
- Reset values: state IDLE; `bus_valid=0`, `bus_we=0`, `bus_be=0`, `bus_addr=0`, `bus_wdata=0`; `Instr=NOP_INSTR`, `OldPC=0`, `ReadData=0`; `misaligned=0`; `Stall=0` while `reset=0`.
- Zero-wait memory (`bus_ready` high the first REQ cycle): 3 cycles per access (IDLE, REQ, DONE). `Stall` is high for 2 of them.
- Each low `bus_ready` cycle in REQ adds 1 cycle of `Stall`.
- Misaligned access: 2 cycles (IDLE, DONE), `Stall` high 1 cycle.
- `Instr`, `OldPC` and `ReadData` are valid from the DONE cycle and held until the next capture.
- `bus_ready` is ignored outside REQ.
- Reset mid-REQ: the next edge forces IDLE and `bus_valid=0`. The transaction is abandoned and no capture occurs.
- Controller inputs must be stable while `Stall=1`. Changes are ignored after the IDLE latch.

## Test plan
- Fetch, zero-wait: `PC=0x100`, `IRWrite=1`, `bus_ready=1`, `rdata=0x00500093` → `bus_addr=0x100`, `be=1111`, `we=0`; in DONE `Instr=0x00500093`, `OldPC=0x100`; `Stall` high exactly 2 cycles.
- SB: `AdrSrc=1`, `ALUResult=0x203`, `WriteData=0x123456AB`, `funct3=000` → `bus_addr=0x200`, `be=1000`, `wdata=0xABABABAB`, `we=1`; `Instr` unchanged.
- Loads at `0x202` with `rdata=0x12F03456`: LB → `ReadData=0xFFFFFFF0`; LBU → `0x000000F0`; LH → `0x000012F0`.
- Wait states: LW at `0x40`, `bus_ready` low 3 cycles → `bus_valid`, `addr`, `be` stable all 4 REQ cycles; `Stall` high 5 cycles; `ReadData=rdata`.
- Misaligned LW at `0x206` → `misaligned` pulse, `bus_valid` never high, `ReadData=0`, `Stall` high 1 cycle. Fetch with `PC=0x102` → same, and `Instr` keeps its old value.
- Reset during REQ with `bus_ready=0`: next edge `bus_valid=0`, `Instr=0x00000013`, state IDLE; a new fetch after release completes normally.
